// File: rtl/ula_sequenciador_pkg.sv
// Shared definitions for the ULA sequencer: opcodes, FSM states, illegal-opcode test.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ula_sequenciador_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 110 and 111 have no ULA driver, so they must never reach it.
  function automatic logic op_ilegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// Request/response bundle between requesters and the ULA sequencer.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the request side and the response side.
interface ula_sequenciador_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0] req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [7:0]         rsp_data;
  logic               rsp_flag;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, rsp_err
  );
endinterface

// File: rtl/ula_sequenciador_arbitro_rr.sv
// Round-robin arbiter: one-hot grant from req_valid starting the search at rr.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module arbitro_rr #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [1:0]       rr,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       winner,
  output logic             any,
  output logic [1:0]       rr_next
);

  logic [3:0] vld4;
  logic [1:0] idx;

  // Scan N_REQ positions from rr; the first valid one wins.
  always_comb begin
    vld4   = 4'(req_valid);
    idx    = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 2'((int'(rr) + k) % N_REQ);
      if (!any && vld4[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = any && (int'(winner) == i);
    end
    rr_next = (int'(winner) == N_REQ - 1) ? 2'd0 : winner + 2'd1;
  end

endmodule

// File: rtl/ula_sequenciador.sv
// Shared ULA controller: round-robin grant, operands held for LATENCY+1 cycles, result returned.
// Latency: legal op answers LATENCY+1 edges after accept; illegal op answers on the accept edge.
// Backpressure: response held stable until rsp_ready; no new grant while busy.
module ula_sequenciador
  import ula_sequenciador_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ula_sequenciador_if.slave    bus,
  output logic [7:0]           ula_a,
  output logic [7:0]           ula_b,
  output logic [2:0]           ula_op,
  input  logic [7:0]           ula_s,
  input  logic                 ula_flag
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  state_t            state;
  logic [1:0]        rr;
  logic [1:0]        id_q;
  logic [CW-1:0]     cnt;
  logic              rsp_valid_q;
  logic [7:0]        rsp_data_q;
  logic              rsp_flag_q;
  logic              rsp_err_q;

  logic [N_REQ-1:0]  grant;
  logic [1:0]        winner;
  logic [1:0]        rr_next;
  logic              any;

  logic [31:0]       a32, b32;
  logic [11:0]       op12;
  logic [7:0]        a_arr [4];
  logic [7:0]        b_arr [4];
  logic [2:0]        op_arr [4];
  logic [7:0]        sel_a, sel_b;
  logic [2:0]        sel_op;

  arbitro_rr #(.N_REQ(N_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .rr        (rr),
    .grant     (grant),
    .winner    (winner),
    .any       (any),
    .rr_next   (rr_next)
  );

  // Unpack the per-requester fields and pick the winner's operands.
  always_comb begin
    a32  = 32'(bus.req_a);
    b32  = 32'(bus.req_b);
    op12 = 12'(bus.req_op);
    for (int i = 0; i < 4; i++) begin
      a_arr[i]  = a32[8*i +: 8];
      b_arr[i]  = b32[8*i +: 8];
      op_arr[i] = op12[3*i +: 3];
    end
    sel_a  = a_arr[winner];
    sel_b  = b_arr[winner];
    sel_op = op_arr[winner];
  end

  // Grants are only offered while idle and out of reset.
  assign bus.req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.rsp_err   = rsp_err_q;

  // Sequencer FSM: accept, hold ULA inputs while the pipeline fills, then present the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr          <= '0;
      id_q        <= '0;
      cnt         <= '0;
      ula_a       <= '0;
      ula_b       <= '0;
      ula_op      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            rr   <= rr_next;
            id_q <= winner;
            if (op_ilegal(sel_op)) begin
              // ULA inputs untouched: the bad opcode never reaches it.
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 8'h00;
              rsp_flag_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= ST_RESP;
            end else begin
              ula_a  <= sel_a;
              ula_b  <= sel_b;
              ula_op <= sel_op;
              cnt    <= CW'(LATENCY);
              state  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_data_q  <= ula_s;
            rsp_flag_q  <= ula_flag;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: directed cases plus random traffic against a behavioural model.
// Latency: a two-stage ULA model sits beside the DUT, as it would in the real top level.
// Backpressure: rsp_ready is held low for varying spans to exercise response stalls.
module tb_ula_sequenciador;
  import ula_sequenciador_pkg::*;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] ula_a, ula_b, ula_s;
  logic [2:0] ula_op;
  logic       ula_flag;

  logic [N-1:0] tv;
  logic [7:0]   ta [N];
  logic [7:0]   tb_b [N];
  logic [2:0]   top [N];
  logic         rsp_ready;

  int errors = 0;
  int checks = 0;
  int mrr    = 0;

  ula_sequenciador_if #(.N_REQ(N)) bus ();

  assign bus.req_valid = tv;
  assign bus.req_a     = {ta[1], ta[0]};
  assign bus.req_b     = {tb_b[1], tb_b[0]};
  assign bus.req_op    = {top[1], top[0]};
  assign bus.rsp_ready = rsp_ready;

  ula_sequenciador #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ula_a    (ula_a),
    .ula_b    (ula_b),
    .ula_op   (ula_op),
    .ula_s    (ula_s),
    .ula_flag (ula_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ULA stand-in: operand register stage, then result register stage; flag combinational.
  logic [7:0] ra, rb;
  always_ff @(posedge clk) begin
    ra <= ula_a;
    rb <= ula_b;
    case (ula_op)
      OP_ADD:  ula_s <= ra + rb;
      OP_SUB:  ula_s <= ra - rb;
      OP_XOR:  ula_s <= ra ^ rb;
      OP_NOT:  ula_s <= ~ra;
      OP_AND:  ula_s <= ra & rb;
      OP_OR:   ula_s <= ra | rb;
      default: ula_s <= 8'hA5;
    endcase
  end
  always_comb begin
    case (ula_op)
      OP_ADD:  ula_flag = ({1'b0, ra} + {1'b0, rb}) > 9'h0FF;
      OP_SUB:  ula_flag = ra < rb;
      default: ula_flag = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid requester at or after the pointer.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (tv[(mrr + k) % N]) return (mrr + k) % N;
    end
    return -1;
  endfunction

  // Expected result computed with plain integer arithmetic.
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  output logic [7:0] d, output logic f, output logic e);
    int s;
    d = 8'h00; f = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); d = 8'(s); f = (s > 255); end
      3'd1: begin s = int'(a) - int'(b); d = 8'(s); f = (s < 0); end
      3'd2: d = a ^ b;
      3'd3: d = ~a;
      3'd4: d = a & b;
      3'd5: d = a | b;
      default: e = 1'b1;
    endcase
  endfunction

  // One transaction, entered just after a negedge with tv/operands already set.
  task automatic serve(input bit keep, input int hold);
    int w, n;
    logic [7:0] ed, pa, pb;
    logic [2:0] po;
    logic ef, ee;
    #1;
    w = pick();
    if (w < 0) w = 0;
    chk("grant", 32'(bus.req_ready), 32'(1 << w));
    ref_alu(ta[w], tb_b[w], top[w], ed, ef, ee);
    pa = ula_a; pb = ula_b; po = ula_op;
    @(posedge clk);
    mrr = (w + 1) % N;
    @(negedge clk);
    if (!keep) tv[w] = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      #1;
      chk("ready_busy", 32'(bus.req_ready), 0);
      chk("ula_a_held", 32'(ula_a), 32'(ta[w]));
      chk("ula_op_held", 32'(ula_op), 32'(top[w]));
      @(negedge clk);
      n++;
    end
    // Illegal: valid in the first cycle after accept; legal: after LAT+1 EXEC cycles.
    chk("latency", n, ee ? 1 : LAT + 2);
    chk("rsp_id", 32'(bus.rsp_id), w);
    chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
    chk("rsp_flag", 32'(bus.rsp_flag), 32'(ef));
    chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
    if (ee) begin
      chk("ula_a_kept", 32'(ula_a), 32'(pa));
      chk("ula_b_kept", 32'(ula_b), 32'(pb));
      chk("ula_op_kept", 32'(ula_op), 32'(po));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_data", 32'(bus.rsp_data), 32'(ed));
      chk("hold_id", 32'(bus.rsp_id), w);
      chk("hold_ready", 32'(bus.req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("valid_clear", 32'(bus.rsp_valid), 0);
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    ta[r] = a; tb_b[r] = b; top[r] = op;
  endtask

  initial begin
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    tv = '0;
    for (int i = 0; i < N; i++) set_req(i, 8'h00, 8'h00, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_ula_a", 32'(ula_a), 0);
    chk("rst_data", 32'(bus.rsp_data), 0);
    chk("rst_err", 32'(bus.rsp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add with carry out.
    set_req(0, 8'hF0, 8'h20, OP_ADD); tv = 2'b01;
    serve(0, 0);
    // Subtract with borrow, then without.
    set_req(1, 8'h05, 8'h07, OP_SUB); tv = 2'b10;
    serve(0, 0);
    set_req(1, 8'h07, 8'h05, OP_SUB); tv = 2'b10;
    serve(0, 0);
    // Illegal opcode.
    set_req(0, 8'h99, 8'h66, 3'b111); tv = 2'b01;
    serve(0, 0);
    // Backpressure with the other requester waiting.
    set_req(0, 8'h5A, 8'h0F, OP_XOR); set_req(1, 8'h81, 8'h00, OP_NOT); tv = 2'b11;
    serve(0, 10);
    // Fairness: both hold valid over 8 operations.
    tv = 2'b11;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)));
      set_req(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)));
      serve(1, 0);
    end
    tv = '0;

    // Reset while cnt==1: aborts the operation, pointer returns to req0.
    set_req(0, 8'h3C, 8'h11, OP_AND); tv = 2'b01;
    #1 chk("pre_rst_grant", 32'(bus.req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    tv = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("exec_rst_valid", 32'(bus.rsp_valid), 0);
    chk("exec_rst_ula_a", 32'(ula_a), 0);
    chk("exec_rst_ula_b", 32'(ula_b), 0);
    chk("exec_rst_ula_op", 32'(ula_op), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mrr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("no_rsp_after_rst", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    set_req(0, 8'h12, 8'h34, OP_OR); set_req(1, 8'h56, 8'h78, OP_ADD); tv = 2'b11;
    serve(0, 0);
    serve(0, 0);

    // Random traffic, including illegal opcodes and random stalls.
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < N; r++) set_req(r, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      if (tv == '0) tv = 2'($urandom_range(1, 3));
      serve(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
